iter_shifter: RTL and testbench
===============================

// Module: iter_shifter
// PURPOSE
//   Parametrised multi-cycle shifter. Successor to the fixed 1-bit right-shift stage.
//   Supports logical left, logical right, arithmetic right and rotate right.
//   Shifts by up to STEP bits per clock; a start/busy/done handshake connects it to the ALU control FSM.
//   Sits beside the ALU; it is used for variable-amount shift instructions.
// PARAMETERS
//   WIDTH  32  operand/result width in bits; power of two, >= 2
//   STEP   4   max bits shifted per cycle; power of two, 1 <= STEP <= WIDTH
//   AMT_W  $clog2(WIDTH) (localparam)  shift-amount width
// PORTS
//   clk      in   1      single clock; all state changes on rising edge
//   rst_n    in   1      asynchronous, active-low reset
//   start    in   1      request; accepted only when state is IDLE or DONE
//   op       in   2      00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled on accept
//   operand  in   WIDTH  value to shift; sampled on accept
//   amount   in   AMT_W  shift distance 0..WIDTH-1; sampled on accept
//   busy     out  1      high while state is SHIFT
//   done     out  1      one-cycle pulse; result valid in the same cycle
//   result   out  WIDTH  shifted value; held from done until the next accept
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, internal regs=0.
//     Reset applied mid-operation aborts the operation; no done is issued.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE:  start=1 -> latch op, operand->acc, amount->rem.
//            If rem==0, go to DONE; otherwise go to SHIFT.
//     SHIFT: each edge shifts acc by s = min(STEP, rem) and sets rem -= s.
//            Go to DONE when the new rem==0; otherwise stay in SHIFT.
//     DONE:  done=1 and result=acc for exactly one cycle.
//            start=1 -> accept back-to-back, with the same transitions as IDLE.
//            Otherwise go to IDLE.
//   start in SHIFT is ignored (not queued). Inputs are don't-care outside the accept cycle.
//   Latency: N = ceil(amount/STEP). done is high in cycle t+N+1, where t is the accept cycle.
//     amount=0 gives done at t+1.
//   Per-step shift semantics on acc, by s bits:
//     SLL: zero fill at LSBs.
//     SRL: zero fill at MSBs.
//     SRA: MSBs filled with the original operand[WIDTH-1].
//     ROR: bits leaving the LSB re-enter at the MSB.
//   Final result equals a single-cycle shift by the full amount. No sticky or carry output.
//   result register updates only on the transition into DONE. busy and done are never both 1.
//   Each step must be implemented as a mux per bit, selected by s; no behavioural >>> on acc.
// TESTING (WIDTH=32, STEP=4 unless stated)
//   1 SRA 0x80000000 by 31 -> done at t+9, result 0xFFFFFFFF; busy high for cycles t+1..t+8.
//   2 SRL 0x80000000 by 31 -> result 0x00000001.
//     SLL 0x00000001 by 5 -> result 0x00000020, done at t+3.
//   3 ROR 0x12345678 by 8 -> result 0x78123456, done at t+3.
//     SLL 0xDEADBEEF by 0 -> result 0xDEADBEEF, done at t+1.
//   4 Handshake:
//     start asserted during SHIFT -> ignored; result unchanged.
//     start during the DONE cycle -> new op accepted, busy the next cycle.
//   5 Reset mid-SHIFT (rst_n low between edges) -> busy, done and result go to 0 at once.
//     After release, the next start completes normally.
//   6 Sweep: random operand, all ops, amount 0..31, STEP in {1,4,32}.
//     Result must match a reference model; latency must equal ceil(amount/STEP)+1.

Source files
------------

// File: rtl/iter_shifter.sv
// Multi-cycle shifter (SLL/SRL/SRA/ROR) moving up to STEP bits per clock.
// Handshake: start accepted in IDLE or DONE; busy during SHIFT; done pulses with result.
module iter_shifter #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned STEP  = 4,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRor = 2'b11;

    // Largest step that can ever be taken; rem never exceeds WIDTH-1.
    localparam int unsigned MaxS = (STEP < WIDTH) ? STEP : WIDTH - 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [AMT_W-1:0] step_s;
    logic [WIDTH-1:0] step_acc;

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] a,
                                                    input logic [AMT_W-1:0] s,
                                                    input logic [1:0]       o,
                                                    input logic             fill);
        logic [WIDTH-1:0] r;
        logic [AMT_W-1:0] idx;
        r   = '0;
        idx = '0;
        for (int k = 0; k <= int'(MaxS); k++) begin
            if (s == AMT_W'(k)) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    case (o)
                        OpSll: begin
                            idx  = AMT_W'(i - k);
                            r[i] = (i >= k) ? a[idx] : 1'b0;
                        end
                        default: begin
                            // Index wraps modulo WIDTH, which is exactly the rotate source.
                            idx = AMT_W'(i + k);
                            if (i + k < int'(WIDTH)) begin
                                r[i] = a[idx];
                            end else begin
                                case (o)
                                    OpSra:   r[i] = fill;
                                    OpRor:   r[i] = a[idx];
                                    OpSrl:   r[i] = 1'b0;
                                    default: r[i] = 1'b0;
                                endcase
                            end
                        end
                    endcase
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        step_s   = (rem_q > AMT_W'(MaxS)) ? AMT_W'(MaxS) : rem_q;
        step_acc = shift_step(acc_q, step_s, op_q, sign_q);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        result_d = result_q;
        case (state_q)
            StShift: begin
                acc_d   = step_acc;
                rem_d   = rem_q - step_s;
                state_d = (rem_d == '0) ? StDone : StShift;
            end
            default: begin
                if (start) begin
                    op_d    = op;
                    acc_d   = operand;
                    rem_d   = amount;
                    sign_d  = operand[WIDTH-1];
                    state_d = (amount == '0) ? StDone : StShift;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
        if (state_d == StDone) begin
            result_d = acc_d;
        end
        busy_d = (state_d == StShift);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench: three shifters (STEP 4, 1, 32) with a per-instance scoreboard
// checking result and latency on every done pulse.
module tb_iter_shifter;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     start_v;
    logic [1:0]     op;
    logic [W-1:0]   operand;
    logic [4:0]     amount;
    logic           busy_w [3];
    logic           done_w [3];
    logic [W-1:0]   res_w  [3];

    int steps [3] = '{4, 1, 32};

    always #5 clk = ~clk;

    iter_shifter #(.WIDTH(32), .STEP(4)) u_dut_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op), .operand(operand),
        .amount(amount), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0])
    );
    iter_shifter #(.WIDTH(32), .STEP(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op), .operand(operand),
        .amount(amount), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1])
    );
    iter_shifter #(.WIDTH(32), .STEP(32)) u_dut_s32 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op), .operand(operand),
        .amount(amount), .busy(busy_w[2]), .done(done_w[2]), .result(res_w[2])
    );

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        int           t0;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] x;
        logic [4:0]   amt;
        logic [W-1:0] res;
    } vec_t;

    exp_t exp_q [3][$];
    exp_t mon_e;
    vec_t tbl [10];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [4:0] a);
        logic [2*W-1:0] dbl;
        logic [W-1:0]   r;
        case (o)
            2'd0:    r = x << a;
            2'd1:    r = x >> a;
            2'd2:    r = $signed(x) >>> a;
            default: begin
                dbl = {x, x} >> a;
                r   = dbl[W-1:0];
            end
        endcase
        return r;
    endfunction

    // Drive a request without waiting; the accept edge is the next rising edge.
    task automatic drive(input logic [2:0] mask, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [4:0] a, input logic [W-1:0] e);
        exp_t ent;
        start_v = mask;
        op      = o;
        operand = x;
        amount  = a;
        for (int d = 0; d < 3; d++) begin
            if (mask[d]) begin
                ent.res = e;
                ent.lat = (int'(a) + steps[d] - 1) / steps[d] + 1;
                ent.t0  = cyc;
                exp_q[d].push_back(ent);
            end
        end
    endtask

    // Returns 1 time unit after the accept edge, i.e. in cycle t+1.
    task automatic issue(input logic [2:0] mask, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [4:0] a, input logic [W-1:0] e);
        @(negedge clk);
        drive(mask, o, x, a, e);
        @(posedge clk);
        #1;
        start_v = 3'b000;
    endtask

    task automatic flush();
        for (int d = 0; d < 3; d++) exp_q[d].delete();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("drain_pending", W'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 0);
        flush();
    endtask

    // Scoreboard monitor: every done pulse pops one expectation for that instance.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            if (done_w[d]) begin
                if (exp_q[d].size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_done dut%0d: got done=1, required done=0", d);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    check($sformatf("result dut%0d", d), res_w[d], mon_e.res);
                    check($sformatf("latency dut%0d", d), W'(cyc - mon_e.t0), W'(mon_e.lat));
                    check($sformatf("busy_with_done dut%0d", d), W'(busy_w[d]), 0);
                end
            end
        end
    end

    initial begin
        start_v = 3'b000;
        op      = 2'd0;
        operand = '0;
        amount  = '0;

        tbl[0] = '{2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        tbl[1] = '{2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001};
        tbl[2] = '{2'd0, 32'h0000_0001, 5'd5,  32'h0000_0020};
        tbl[3] = '{2'd3, 32'h1234_5678, 5'd8,  32'h7812_3456};
        tbl[4] = '{2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        tbl[5] = '{2'd2, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
        tbl[6] = '{2'd3, 32'h0000_0001, 5'd1,  32'h8000_0000};
        tbl[7] = '{2'd2, 32'hF000_0000, 5'd3,  32'hFE00_0000};
        tbl[8] = '{2'd0, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
        tbl[9] = '{2'd3, 32'hDEAD_BEEF, 5'd31, 32'hBD5B_7DDF};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_busy dut%0d", d), W'(busy_w[d]), 0);
            check($sformatf("reset_done dut%0d", d), W'(done_w[d]), 0);
            check($sformatf("reset_result dut%0d", d), res_w[d], 0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(3'b111, tbl[i].op, tbl[i].x, tbl[i].amt, tbl[i].res);
            wait_idle();
        end

        // Long SRA: busy over t+1..t+8, done at t+9; a start during SHIFT is ignored.
        issue(3'b001, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("sra31_busy t+%0d", k), W'(busy_w[0]), 1);
            check($sformatf("sra31_done t+%0d", k), W'(done_w[0]), 0);
            if (k == 3) begin
                start_v = 3'b001;
                op      = 2'd0;
                operand = 32'h0000_5555;
                amount  = 5'd1;
            end
            if (k == 4) start_v = 3'b000;
            @(posedge clk);
            #1;
        end
        check("sra31_done t+9", W'(done_w[0]), 1);
        check("sra31_busy t+9", W'(busy_w[0]), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("ignored_start_busy", W'(busy_w[0]), 0);
        check("ignored_start_done", W'(done_w[0]), 0);
        check("ignored_start_result", res_w[0], 32'hFFFF_FFFF);
        wait_idle();

        // Back-to-back: accept a new request in the DONE cycle.
        issue(3'b001, 2'd0, 32'h0000_0001, 5'd5, 32'h0000_0020);
        @(posedge clk);
        #1;
        check("b2b_first_busy", W'(busy_w[0]), 1);
        @(posedge clk);
        #1;
        check("b2b_first_done", W'(done_w[0]), 1);
        drive(3'b001, 2'd3, 32'h1234_5678, 5'd8, 32'h7812_3456);
        @(posedge clk);
        #1;
        start_v = 3'b000;
        check("b2b_second_busy", W'(busy_w[0]), 1);
        check("b2b_second_done", W'(done_w[0]), 0);
        check("b2b_result_held", res_w[0], 32'h0000_0020);
        wait_idle();

        // Reset between edges mid-SHIFT clears outputs immediately.
        issue(3'b011, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_busy dut%0d", d), W'(busy_w[d]), 0);
            check($sformatf("midrst_done dut%0d", d), W'(done_w[d]), 0);
            check($sformatf("midrst_result dut%0d", d), res_w[d], 0);
        end
        flush();
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'b011, 2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001);
        wait_idle();

        // Sweep all ops and amounts with random operands across three STEP values.
        for (int o = 0; o < 4; o++) begin
            for (int a = 0; a < 32; a++) begin
                logic [W-1:0] x;
                x = $urandom;
                issue(3'b111, 2'(o), x, 5'(a), ref_shift(2'(o), x, 5'(a)));
                wait_idle();
            end
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
